fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the FIFO word width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the pop counter width.
REQ-003 Port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 Port rrst_n  input  1  reset, synchronous, active-low.
REQ-005 Port rempty  input  1  FIFO empty flag from the read-pointer stage.
REQ-006 Port rdata  input  DATA_WIDTH  FIFO word at the current raddr; valid whenever rempty=0.
REQ-007 Port rinc  output  1  pop request to the read-pointer stage.
REQ-008 Port flush  input  1  discard all buffered words.
REQ-009 Port out_valid  output  1  stream word available.
REQ-010 Port out_ready  input  1  downstream accepts the word.
REQ-011 Port out_data  output  DATA_WIDTH  stream word, the head entry.
REQ-012 Port occupancy  output  2  number of buffered words, 0 to 2.
REQ-013 Port pop_count  output  CNT_WIDTH  number of FIFO pops since reset.

Function
REQ-014 The block SHALL hold a 2-entry in-order buffer; the states are EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-015 rinc SHALL be combinational: rinc = rrst_n & ~rempty & ~flush & (occupancy<2 | out_ready).
REQ-016 When rinc=1, the block SHALL write rdata into the buffer tail at that rising edge (one-word pop per cycle).
REQ-017 out_valid SHALL be (occupancy!=0) & ~flush, and out_data SHALL be the registered head entry; there is no combinational path from rdata to out_data.
REQ-018 A stream transfer SHALL occur when out_valid=1 and out_ready=1; the head entry is removed at that edge.
REQ-019 Push only: EMPTY->ONE, ONE->FULL.
REQ-020 Pop only: FULL->ONE, ONE->EMPTY.
REQ-021 Push and pop in the same cycle: occupancy is unchanged and order is preserved. In ONE, the new word becomes head the next cycle; in FULL, the second entry moves to head and the new word goes to tail.
REQ-022 In EMPTY, a push SHALL present the word on out_data with out_valid=1 one cycle after the rinc edge (latency 1).
REQ-023 Words SHALL leave out_data in exactly FIFO pop order, with no loss or duplication.
REQ-024 In FULL with out_ready=0, rinc SHALL be 0 and the buffer contents SHALL hold stable.
REQ-025 While rempty=1, rinc SHALL be 0; buffered words continue to drain.
REQ-026 flush=1 SHALL force rinc=0 and out_valid=0, and set occupancy to 0 at the edge; no transfer is counted in a flush cycle.
REQ-027 pop_count SHALL increment by 1 on every edge where rinc=1, wrap modulo 2^CNT_WIDTH, and be unaffected by flush.
REQ-028 The buffer SHALL never overflow or underflow for any input sequence.

Reset
REQ-029 At a rising edge with rrst_n=0, the block SHALL set occupancy=0, pop_count=0 and both entries to 0.
REQ-030 While rrst_n=0, rinc=0 and out_valid=0 regardless of other inputs; out_data=0 after the reset edge.
REQ-031 Reset asserted mid-operation SHALL discard buffered words; operation SHALL resume normally on the first edge with rrst_n=1.

Verification
REQ-032 Stream: rdata 0x11,0x22,0x33 with rempty=0 and out_ready=1 -> rinc high 3 cycles; out_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle later; pop_count=3.
REQ-033 Backpressure: out_ready=0, rempty=0 -> occupancy 1 then 2, then rinc=0. Raise out_ready -> rinc resumes the same cycle; order preserved.
REQ-034 Empty: rempty=1 with occupancy=2 and out_ready=1 -> two transfers, occupancy 0, out_valid=0, rinc=0 throughout.
REQ-035 Flush in FULL with rempty=0 -> that cycle rinc=0 and out_valid=0; next cycle occupancy=0; pop_count unchanged.
REQ-036 Counter wrap: CNT_WIDTH=4, 17 pops -> pop_count=1.
REQ-037 Reset mid-stream with occupancy=2 -> after the edge occupancy=0, pop_count=0, out_valid=0; after release the next word streams with latency 1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter: pops the async FIFO into a 2-entry skid buffer
// and presents a registered valid/ready stream with a wrapping pop counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   head_q;
  logic [DATA_WIDTH-1:0]   tail_q;
  logic [DATA_WIDTH-1:0]   head_d;
  logic [DATA_WIDTH-1:0]   tail_d;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    push;
  logic                    pop;
  logic                    has_room;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: if (push) state_d = S_ONE;
        S_ONE: begin
          if (push && !pop) state_d = S_FULL;
          else if (!push && pop) state_d = S_EMPTY;
        end
        S_FULL: if (pop && !push) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Head always holds the oldest word; a pop in FULL shifts tail forward.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      S_EMPTY: if (push) head_d = rdata;
      S_ONE: begin
        if (push && pop) head_d = rdata;
        else if (push) tail_d = rdata;
      end
      S_FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    has_room  = (state_q != S_FULL);
    rinc      = rrst_n & ~rempty & ~flush
              & (has_room | out_ready);
    out_valid = rrst_n & ~flush & (state_q != S_EMPTY);
    push      = rinc;
    pop       = out_valid & out_ready;
    out_data  = head_q;
    occupancy = state_q;
    pop_count = cnt_q;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: queue model checked every cycle
// plus literal expectations at key points.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] pop_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];
  int            mcnt = 0;
  bit            known = 0;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .rempty(rempty),
    .rdata(rdata),
    .rinc(rinc),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .pop_count(pop_count)
  );

  initial rclk = 0;
  always #5 rclk = ~rclk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", n, a, e);
    end
  endtask

  function automatic logic m_rinc();
    return rrst_n && !rempty && !flush
        && (mq.size() < 2 || out_ready);
  endfunction

  function automatic logic m_valid();
    return rrst_n && !flush && mq.size() != 0;
  endfunction

  always @(posedge rclk) begin
    logic r, v;
    r = m_rinc();
    v = m_valid();
    if (!rrst_n) begin
      mq.delete();
      mcnt = 0;
      known = 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (v && out_ready) void'(mq.pop_front());
      if (r) begin
        mq.push_back(rdata);
        mcnt = (mcnt + 1) % (1 << CW);
      end
    end
  end

  always @(negedge rclk) begin
    chk("rinc", 32'(rinc), 32'(m_rinc()));
    chk("out_valid", 32'(out_valid), 32'(m_valid()));
    if (known) begin
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("pop_count", 32'(pop_count), 32'(mcnt));
      if (m_valid())
        chk("out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  task automatic cyc(logic e, logic [DW-1:0] d, logic r, logic f);
    rempty    = e;
    rdata     = d;
    out_ready = r;
    flush     = f;
    @(posedge rclk);
    #2;
  endtask

  initial begin
    rrst_n = 0; rempty = 0; rdata = 8'h5a;
    out_ready = 1; flush = 0;
    #1;
    chk("rst_rinc", 32'(rinc), 0);
    chk("rst_valid", 32'(out_valid), 0);
    @(posedge rclk); #2;
    @(posedge rclk); #2;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_cnt", 32'(pop_count), 0);
    chk("rst_data", 32'(out_data), 0);
    rrst_n = 1;

    cyc(0, 8'h11, 1, 0);
    chk("s1_valid", 32'(out_valid), 1);
    chk("s1_data", 32'(out_data), 32'h11);
    chk("s1_occ", 32'(occupancy), 1);
    cyc(0, 8'h22, 1, 0);
    chk("s2_data", 32'(out_data), 32'h22);
    cyc(0, 8'h33, 1, 0);
    chk("s3_data", 32'(out_data), 32'h33);
    chk("s3_cnt", 32'(pop_count), 3);
    cyc(1, 8'h00, 1, 0);
    chk("s4_occ", 32'(occupancy), 0);
    chk("s4_valid", 32'(out_valid), 0);

    cyc(0, 8'h44, 0, 0);
    chk("bp1_occ", 32'(occupancy), 1);
    cyc(0, 8'h55, 0, 0);
    chk("bp2_occ", 32'(occupancy), 2);
    rempty = 0; rdata = 8'h66; out_ready = 0;
    #1;
    chk("bp_full_rinc", 32'(rinc), 0);
    @(posedge rclk); #2;
    chk("bp_hold_occ", 32'(occupancy), 2);
    chk("bp_hold_data", 32'(out_data), 32'h44);
    out_ready = 1;
    #1;
    chk("bp_resume_rinc", 32'(rinc), 1);
    @(posedge rclk); #2;
    chk("bp_pp_data", 32'(out_data), 32'h55);
    chk("bp_pp_occ", 32'(occupancy), 2);
    cyc(1, 8'h00, 1, 0);
    chk("bp_d1_data", 32'(out_data), 32'h66);
    cyc(1, 8'h00, 1, 0);
    chk("bp_d2_occ", 32'(occupancy), 0);
    chk("bp_cnt", 32'(pop_count), 6);

    cyc(0, 8'h77, 0, 0);
    cyc(0, 8'h88, 0, 0);
    rempty = 1; out_ready = 1;
    #1;
    chk("em_rinc", 32'(rinc), 0);
    @(posedge rclk); #2;
    chk("em_data", 32'(out_data), 32'h88);
    chk("em_occ1", 32'(occupancy), 1);
    cyc(1, 8'h00, 1, 0);
    chk("em_occ0", 32'(occupancy), 0);
    chk("em_valid", 32'(out_valid), 0);
    chk("em_cnt", 32'(pop_count), 8);

    cyc(0, 8'h99, 0, 0);
    cyc(0, 8'haa, 0, 0);
    chk("fl_pre_occ", 32'(occupancy), 2);
    rempty = 0; rdata = 8'hbb; out_ready = 1; flush = 1;
    #1;
    chk("fl_rinc", 32'(rinc), 0);
    chk("fl_valid", 32'(out_valid), 0);
    @(posedge rclk); #2;
    flush = 0;
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_cnt", 32'(pop_count), 10);

    cyc(0, 8'hc1, 0, 0);
    cyc(0, 8'hc2, 0, 0);
    chk("mr_pre_occ", 32'(occupancy), 2);
    rrst_n = 0; rempty = 0; rdata = 8'hc3; out_ready = 1;
    #1;
    chk("mr_rinc", 32'(rinc), 0);
    chk("mr_valid", 32'(out_valid), 0);
    @(posedge rclk); #2;
    chk("mr_occ", 32'(occupancy), 0);
    chk("mr_cnt", 32'(pop_count), 0);
    chk("mr_data", 32'(out_data), 0);
    rrst_n = 1;
    cyc(0, 8'hd0, 1, 0);
    chk("mr_lat_valid", 32'(out_valid), 1);
    chk("mr_lat_data", 32'(out_data), 32'hd0);
    chk("mr_lat_cnt", 32'(pop_count), 1);

    for (int i = 1; i <= 16; i++)
      cyc(0, 8'(8'hd0 + i), 1, 0);
    chk("wrap_cnt", 32'(pop_count), 1);
    chk("wrap_data", 32'(out_data), 32'he0);
    cyc(1, 8'h00, 1, 0);
    cyc(1, 8'h00, 1, 0);
    chk("end_occ", 32'(occupancy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
